// File: rtl/pixel_defs.sv
// Shared screen geometry and pixel entry type for the pixel write path.
// Used by pixel_fifo, pixel_write_sink_if and pixel_write_sink.
package pixel_defs;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOUR_W  = 3;
  localparam int FB_ADDR_W = 15;
  localparam int PIX_W     = X_W + Y_W + COLOUR_W;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*160 + x as two shifts and adds, wrapping at 15 bits
  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    logic [FB_ADDR_W-1:0] w_y;
    w_y = FB_ADDR_W'(y);
    return (w_y << 7) + (w_y << 5) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Pixel-write input and framebuffer write-port bundle.
// master: drawer/memory side, slave: pixel_write_sink.
interface pixel_write_sink_if;
  import pixel_defs::*;

  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [COLOUR_W-1:0]  colour;
  logic                 writeEn;
  logic                 full;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic [COLOUR_W-1:0]  mem_data;
  logic                 mem_we;
  logic                 mem_ready;

  modport master (
    output x, y, colour, writeEn, mem_ready,
    input  full, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  x, y, colour, writeEn, mem_ready,
    output full, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module pixel_fifo
  import pixel_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = PIX_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers drawer pixel writes and drains them to the framebuffer port.
// `define PIXEL_CLIP_EN to discard off-screen writes and add the clipped flag.
module pixel_write_sink
  import pixel_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  pixel_write_sink_if.slave bus,
  output logic             overflow,
`ifdef PIXEL_CLIP_EN
  output logic             clipped,
`endif
  output logic [CNT_W-1:0] pix_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pixel_t               w_in;
  pixel_t               w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic                 w_oor;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_load;
  logic                 w_drain;

  logic [FB_ADDR_W-1:0] r_addr;
  logic [COLOUR_W-1:0]  r_data;
  logic                 r_we;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_pix_count;

  assign w_in = '{x: bus.x, y: bus.y, colour: bus.colour};

`ifdef PIXEL_CLIP_EN
  logic r_clipped;

  assign w_oor = (bus.x >= X_W'(SCREEN_W))
              || (bus.y >= Y_W'(SCREEN_H));
  assign clipped = r_clipped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_clipped <= 1'b0;
    else if (clear)
      r_clipped <= 1'b0;
    else if (bus.writeEn && w_oor)
      r_clipped <= 1'b1;
  end
`else
  assign w_oor = 1'b0;
`endif

  assign w_req    = bus.writeEn && !w_oor;
  assign w_accept = w_req && !w_full;
  assign w_drop   = w_req && w_full;
  assign w_load   = (w_count != '0) && (!r_we || bus.mem_ready);
  assign w_drain  = r_we && bus.mem_ready && w_empty;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_accept),
    .pop     (w_load),
    .din     (w_in),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else if (w_load) begin
      r_addr <= fb_addr(w_head.x, w_head.y);
      r_data <= w_head.colour;
      r_we   <= 1'b1;
    end else if (w_drain) begin
      r_we   <= 1'b0;
    end
  end

  // clear outranks a same-cycle accept or drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_pix_count <= '0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_pix_count <= '0;
    end else begin
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_accept)
        r_pix_count <= r_pix_count + CNT_W'(1);
    end
  end

  assign bus.full     = w_full;
  assign bus.mem_addr = r_addr;
  assign bus.mem_data = r_data;
  assign bus.mem_we   = r_we;
  assign overflow     = r_overflow;
  assign pix_count    = r_pix_count;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink (DEPTH=8).
// Covers clip behaviour too when PIXEL_CLIP_EN is defined.
module tb_pixel_write_sink;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             overflow;
  logic [CNT_W-1:0] pix_count;
`ifdef PIXEL_CLIP_EN
  logic             clipped;
`endif

  int n_tests;
  int n_fail;

  pixel_write_sink_if bus();

  pixel_write_sink #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .bus       (bus),
    .overflow  (overflow),
`ifdef PIXEL_CLIP_EN
    .clipped   (clipped),
`endif
    .pix_count (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(
    input int x,
    input int y,
    input int c,
    input bit we
  );
    bus.x       = 8'(x);
    bus.y       = 7'(y);
    bus.colour  = 3'(c);
    bus.writeEn = we;
  endtask

  function automatic int ref_addr(input int x, input int y);
    return (y * 160 + x) % 32768;
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    clear   = 1'b0;
    drive(0, 0, 0, 1'b0);
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rst_full", 32'(bus.full), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_data", 32'(bus.mem_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_cnt", 32'(pix_count), 0);
    reset_n = 1'b1;
    step();

    // single pixel
    drive(3, 2, 5, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("single_k", 32'(bus.mem_we), 0);
    step();
    check("single_we", 32'(bus.mem_we), 1);
    check("single_addr", 32'(bus.mem_addr), 323);
    check("single_data", 32'(bus.mem_data), 5);
    check("single_cnt", 32'(pix_count), 1);
    step();
    check("single_end", 32'(bus.mem_we), 0);

    // corner addresses back to back
    drive(159, 119, 7, 1'b1);
    step();
    drive(0, 0, 1, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("corner_max", 32'(bus.mem_addr), 19199);
    check("corner_max_we", 32'(bus.mem_we), 1);
    step();
    check("corner_zero", 32'(bus.mem_addr), 0);
    check("corner_zero_d", 32'(bus.mem_data), 1);
    check("corner_zero_we", 32'(bus.mem_we), 1);
    step();
    check("corner_end", 32'(bus.mem_we), 0);

    // backpressure: DEPTH+2 pushes with memory stalled
    pulse_clear();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(10 * i + 1, i, i % 8, 1'b1);
      step();
      if (i >= 1) begin
        check("bp_hold_we", 32'(bus.mem_we), 1);
        check("bp_hold_addr", 32'(bus.mem_addr), ref_addr(1, 0));
      end
    end
    drive(0, 0, 0, 1'b0);
    check("bp_full", 32'(bus.full), 1);
    check("bp_ovf", 32'(overflow), 1);
    check("bp_cnt", 32'(pix_count), DEPTH + 1);
    bus.mem_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      check("bp_drain_we", 32'(bus.mem_we), 1);
      check("bp_drain_addr", 32'(bus.mem_addr), ref_addr(10 * i + 1, i));
      check("bp_drain_data", 32'(bus.mem_data), i % 8);
    end
    check("bp_notfull", 32'(bus.full), 0);
    step();
    check("bp_drain_end", 32'(bus.mem_we), 0);

    // streaming 100 pixels
    pulse_clear();
    check("clr_ovf", 32'(overflow), 0);
    check("clr_cnt", 32'(pix_count), 0);
    for (int s = 1; s <= 102; s++) begin
      if (s <= 100)
        drive(s - 1 + 30, ((s - 1) * 7) % 120, (s - 1) % 8, 1'b1);
      else
        drive(0, 0, 0, 1'b0);
      step();
      check("st_full", 32'(bus.full), 0);
      if (s >= 2 && s <= 101) begin
        check("st_we", 32'(bus.mem_we), 1);
        check("st_pix", {14'd0, bus.mem_addr, bus.mem_data},
              (ref_addr(s - 2 + 30, ((s - 2) * 7) % 120) << 3)
              + ((s - 2) % 8));
      end else if (s == 102) begin
        check("st_end", 32'(bus.mem_we), 0);
      end
    end
    check("st_cnt", 32'(pix_count), 100);

    // clear in the same cycle as a dropped push
    bus.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(i, i, i % 8, 1'b1);
      step();
    end
    check("ce_ovf_set", 32'(overflow), 1);
    check("ce_cnt_pre", 32'(pix_count), 100 + DEPTH + 1);
    drive(50, 50, 3, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(0, 0, 0, 1'b0);
    check("ce_ovf", 32'(overflow), 0);
    check("ce_cnt", 32'(pix_count), 0);
    check("ce_full_kept", 32'(bus.full), 1);
    check("ce_stage_kept", 32'(bus.mem_addr), ref_addr(0, 0));
    check("ce_we_kept", 32'(bus.mem_we), 1);

    // async reset with 4 buffered pixels and the stage loaded
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(i + 5, 1, 2, 1'b1);
      step();
    end
    drive(0, 0, 0, 1'b0);
    check("rd_we_pre", 32'(bus.mem_we), 1);
    check("rd_cnt_pre", 32'(pix_count), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("rd_we_async", 32'(bus.mem_we), 0);
    check("rd_cnt_async", 32'(pix_count), 0);
    check("rd_addr_async", 32'(bus.mem_addr), 0);
    #3;
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_no_stale", 32'(bus.mem_we), 0);
    end

`ifdef PIXEL_CLIP_EN
    drive(200, 5, 4, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("clip_flag", 32'(clipped), 1);
    check("clip_cnt", 32'(pix_count), 0);
    check("clip_ovf", 32'(overflow), 0);
    step();
    check("clip_no_xfer", 32'(bus.mem_we), 0);
    pulse_clear();
    check("clip_clr", 32'(clipped), 0);
`else
    drive(200, 0, 4, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("noclip_cnt", 32'(pix_count), 1);
    step();
    check("noclip_we", 32'(bus.mem_we), 1);
    check("noclip_addr", 32'(bus.mem_addr), 200);
    step();
    check("noclip_end", 32'(bus.mem_we), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_sink.md
Name: pixel_write_sink

Overview:
- Receiving end of the drawing engines' pixel-write interface (x, y, colour, writeEn).
- Buffers incoming pixel writes in a small FIFO and converts each (x,y) to a linear framebuffer address (y*160 + x).
- Drains to a single-port framebuffer write port with ready/valid backpressure.
- Sits between the card/symbol drawing FSMs and the framebuffer RAM. Lets drawers run without stalling when the memory side is briefly busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-pixel counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- x  input  8  pixel column, 0..159.
- y  input  7  pixel row, 0..119.
- colour  input  3  pixel colour.
- writeEn  input  1  pixel write strobe; one pixel per cycle while high.
- clear  input  1  synchronous clear of overflow and pix_count.
- full  output  1  FIFO holds DEPTH entries.
- mem_addr  output  15  framebuffer address, y*160 + x.
- mem_data  output  3  colour to write.
- mem_we  output  1  valid: output stage holds a pixel.
- mem_ready  input  1  framebuffer accepts; transfer when mem_we && mem_ready.
- overflow  output  1  sticky; a write was dropped.
- pix_count  output  CNT_W  pixels accepted into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO is emptied: rd_ptr = wr_ptr = 0, count = 0.
  - full=0, mem_we=0, mem_addr=0, mem_data=0, overflow=0, pix_count=0.
  - Reset mid-transfer discards all buffered pixels and the pixel in the output stage.
- Push:
  - A pixel is pushed on a rising edge where writeEn=1 and full=0.
  - full is computed from the registered count. A push while full is dropped even if a pop happens in the same cycle.
  - A dropped push sets overflow=1 and does not increment pix_count.
- Output stage: one register stage holding {mem_addr, mem_data} plus mem_we.
  - The stage loads from the FIFO head on an edge where the FIFO is non-empty and either (mem_we=0) or (mem_we && mem_ready). The same edge pops the FIFO.
  - mem_we clears on an edge where a transfer occurs and the FIFO is empty.
- Latency and throughput:
  - There is no bypass. A pixel pushed at edge k is presented with mem_we=1 after edge k+1 at the earliest.
  - Sustained throughput is 1 pixel/cycle while mem_ready=1.
- Backpressure:
  - While mem_we=1 and mem_ready=0, mem_addr, mem_data and mem_we hold stable.
  - The FIFO keeps accepting pushes until full.
- Address arithmetic:
  - mem_addr = (y<<7) + (y<<5) + x, computed in 15 bits.
  - Maximum legal value is 19199 (y=119, x=159).
- Counters and clear:
  - count is the registered number of FIFO entries, 0..DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - pix_count increments by 1 per accepted push.
  - clear=1 zeroes overflow and pix_count on that edge. If a push or drop also occurs that cycle, clear wins (result is 0).
  - clear does not touch FIFO contents or the output stage.
- Ordering: pixels reach the memory port in strict arrival order, with none duplicated.

Optional Feature:
- Macro: PIXEL_CLIP_EN.
- Defined:
  - A write with x>159 or y>119 is discarded at the input: not pushed, pix_count unchanged, overflow unaffected.
  - An extra output port clipped (1 bit, sticky, reset 0, cleared by clear) is set by any discarded write.
- Undefined:
  - Out-of-range coordinates are pushed and their address is computed modulo 2^15 with no check.
  - The clipped port is absent.

Decomposition:
- Shared package/header pixel_defs holds:
  - SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3, FB_ADDR_W=15.
  - Packed pixel entry width = X_W+Y_W+COLOUR_W = 18.
- One sub-module, pixel_fifo:
  - Parameterised by DEPTH and data width.
  - Ports: push, pop, din, dout (head), full, empty, count; async active-low reset.
- The top holds the address computation, the output stage, and the counters.

Test Plan:
- Single pixel: after reset, drive x=3, y=2, colour=5, writeEn for 1 cycle with mem_ready=1. mem_we is high exactly 1 cycle, starting 2 edges later, with mem_addr=323, mem_data=5; pix_count=1.
- Corner address: x=159, y=119 -> mem_addr=19199. x=0, y=0 -> mem_addr=0.
- Backpressure: mem_ready=0, push DEPTH+2 pixels on consecutive cycles.
  - Output stage holds the first pixel stable and full=1.
  - The last pixel is dropped and overflow=1; pix_count=DEPTH+1.
  - Then set mem_ready=1: DEPTH+1 pixels drain in order, 1 per cycle.
- Streaming: 100 consecutive pixels with mem_ready=1 -> 100 transfers, in order, no gaps after the first, full never asserted.
- Clear vs event: clear asserted in the same cycle as a dropped push -> overflow=0 and pix_count=0 afterwards.
- Reset mid-drain: async reset_n low with 4 entries buffered and mem_ready=0 -> mem_we=0 immediately; after release, no stale pixel appears. With PIXEL_CLIP_EN: x=200 -> no transfer, clipped=1.
